// File: rtl/serial_pkg.sv
// serial_pkg: shared constants for the serial transmit framer.
// Build option SERIAL_TX_PARITY_EN: adds an even-parity bit, giving an 11-bit frame.
package serial_pkg;

  localparam int DATA_W = 8;

`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 3;
`else
  localparam int FRAME_BITS = DATA_W + 2;
`endif

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/bit_timer.sv
// bit_timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
// Held at zero while restart is high, so a new frame always begins at count 0.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic Clk,
  input  logic Clear,
  input  logic restart,
  output logic tick
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt;

  // Count up and wrap on the final cycle of a bit period.
  always_ff @(negedge Clk) begin
    if (Clear || restart || (cnt == LAST)) cnt <= '0;
    else                                   cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_tx_framer.sv
// serial_tx_framer: sends one accepted byte as start | 8 data | [parity] | stop.
// All state changes on the falling edge of Clk, matching the upstream shift register.
// Build option SERIAL_TX_PARITY_EN inserts an even-parity bit before stop.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | line high, Ready high, waiting for Valid
// ST_START  | start bit (low) for one bit period
// ST_DATA   | data bit idx, order chosen by latched Dir
// ST_PARITY | XOR of latched byte (parity builds only)
// ST_STOP   | stop bit (high); Done pulses on exit to idle
module serial_tx_framer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = serial_pkg::DATA_W
) (
  input  logic              Clk,
  input  logic              Clear,
  input  logic [0:DATA_W-1] Data,
  input  logic              Dir,
  input  logic              Valid,
  output logic              Ready,
  output logic              Tx,
  output logic              Busy,
  output logic              Done
);

  import serial_pkg::*;

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_t            state, state_nx;
  logic [IW-1:0]     idx, idx_nx;
  logic [0:DATA_W-1] data_q;
  logic              dir_q;
  logic              tick;
  logic              in_idle;
  logic              line_bit;
  logic              tx_nx;

  assign in_idle = (state == ST_IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .Clk    (Clk),
    .Clear  (Clear),
    .restart(in_idle),
    .tick   (tick)
  );

  // Next state, next bit index, and the line level the next state will drive.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    line_bit = 1'b0;
    tx_nx    = IDLE_LEVEL;
    case (state)
      ST_IDLE: begin
        if (Valid) begin
          state_nx = ST_START;
          idx_nx   = '0;
        end
      end
      ST_START: begin
        if (tick) state_nx = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (idx == LAST_IDX) begin
            idx_nx = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_nx = ST_PARITY;
`else
            state_nx = ST_STOP;
`endif
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_nx = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase

    // Only the latched copy of the byte ever reaches the line.
    line_bit = dir_q ? data_q[LAST_IDX - idx_nx] : data_q[idx_nx];

    case (state_nx)
      ST_START:  tx_nx = 1'b0;
      ST_DATA:   tx_nx = line_bit;
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: tx_nx = ^data_q;
`endif
      default:   tx_nx = IDLE_LEVEL;
    endcase
  end

  // State register and registered outputs; Clear overrides everything.
  always_ff @(negedge Clk) begin
    if (Clear) begin
      state <= ST_IDLE;
      idx   <= '0;
      Tx    <= IDLE_LEVEL;
      Ready <= 1'b1;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      Tx    <= tx_nx;
      Ready <= (state_nx == ST_IDLE);
      Busy  <= (state_nx != ST_IDLE);
      Done  <= (state == ST_STOP) && (state_nx == ST_IDLE);
    end
  end

  // Capture the byte and bit order only on the accepting edge.
  always_ff @(negedge Clk) begin
    if (Clear) begin
      data_q <= '0;
      dir_q  <= 1'b0;
    end else if (in_idle && Valid) begin
      data_q <= Data;
      dir_q  <= Dir;
    end
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// tb_serial_tx_framer: random and directed frames checked against a bit-list model.
`timescale 1ns/1ps
module tb_serial_tx_framer;
  import serial_pkg::*;

  localparam int CPB = 4;

  logic       Clk;
  logic       Clear;
  logic [0:7] Data;
  logic       Dir;
  logic       Valid;
  logic       Ready;
  logic       Tx;
  logic       Busy;
  logic       Done;

  int compared   = 0;
  int mismatched = 0;

  bit exp_line[$];

  serial_tx_framer #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .Clk  (Clk),
    .Clear(Clear),
    .Data (Data),
    .Dir  (Dir),
    .Valid(Valid),
    .Ready(Ready),
    .Tx   (Tx),
    .Busy (Busy),
    .Done (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic obs, input logic exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line level per clock: the frame as a list of bits, each repeated CPB times.
  // Numerically b[7] is Data[0], so Dir=0 sends b MSB-first and Dir=1 sends it LSB-first.
  task automatic build_frame(input logic [7:0] b, input logic d);
    bit bits[$];
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d ? b[i] : b[7-i]);
`ifdef SERIAL_TX_PARITY_EN
    bits.push_back(($countones(b) % 2) == 1);
`endif
    bits.push_back(1'b1);
    exp_line = {};
    foreach (bits[k])
      for (int c = 0; c < CPB; c++) exp_line.push_back(bits[k]);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      check_val("idle_tx",    Tx,    1'b1);
      check_val("idle_ready", Ready, 1'b1);
      check_val("idle_busy",  Busy,  1'b0);
      check_val("idle_done",  Done,  1'b0);
    end
  endtask

  // Called at a posedge with the framer idle; returns at the posedge showing Done.
  task automatic send_frame(input logic [7:0] b, input logic d, input bit hold_valid);
    build_frame(b, d);
    check_val("entry_ready", Ready, 1'b1);
    check_val("entry_tx",    Tx,    1'b1);
    check_val("entry_busy",  Busy,  1'b0);
    Data  = b;
    Dir   = d;
    Valid = 1'b1;
    for (int i = 0; i < exp_line.size(); i++) begin
      @(posedge Clk);
      check_val("frame_tx",    Tx,    exp_line[i]);
      check_val("frame_busy",  Busy,  1'b1);
      check_val("frame_ready", Ready, 1'b0);
      check_val("frame_done",  Done,  1'b0);
      Valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
      Data  = (i % 2 == 1) ? 8'hFF : 8'($urandom);
      Dir   = 1'($urandom_range(0, 1));
    end
    @(posedge Clk);
    check_val("done_pulse", Done,  1'b1);
    check_val("done_ready", Ready, 1'b1);
    check_val("done_tx",    Tx,    1'b1);
    check_val("done_busy",  Busy,  1'b0);
    Valid = 1'b0;
  endtask

  // Start a frame, watch `cut` cycles of it, then pulse Clear for one edge.
  task automatic abort_frame(input logic [7:0] b, input logic d, input int cut);
    build_frame(b, d);
    Data  = b;
    Dir   = d;
    Valid = 1'b1;
    for (int i = 0; i < cut; i++) begin
      @(posedge Clk);
      check_val("pre_abort_tx", Tx, exp_line[i]);
      Valid = 1'b0;
    end
    Clear = 1'b1;
    @(posedge Clk);
    check_val("abort_tx",    Tx,    1'b1);
    check_val("abort_ready", Ready, 1'b1);
    check_val("abort_busy",  Busy,  1'b0);
    check_val("abort_done",  Done,  1'b0);
    Clear = 1'b0;
    idle_cycles(FRAME_BITS * CPB + 2);
  endtask

  task automatic clear_with_valid();
    Clear = 1'b1;
    Valid = 1'b1;
    Data  = 8'($urandom);
    @(posedge Clk);
    check_val("cv_tx",    Tx,    1'b1);
    check_val("cv_ready", Ready, 1'b1);
    check_val("cv_busy",  Busy,  1'b0);
    Clear = 1'b0;
    Valid = 1'b0;
    idle_cycles(2 * CPB);
  endtask

  initial begin
    Clear = 1'b1;
    Valid = 1'b0;
    Data  = '0;
    Dir   = 1'b0;
    repeat (3) @(posedge Clk);
    check_val("rst_tx",    Tx,    1'b1);
    check_val("rst_ready", Ready, 1'b1);
    check_val("rst_busy",  Busy,  1'b0);
    check_val("rst_done",  Done,  1'b0);
    Clear = 1'b0;
    idle_cycles(2);

    send_frame(8'h0F, 1'b0, 1'b0);
    idle_cycles(1);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle_cycles(2);
    send_frame(8'h07, 1'b0, 1'b0);
    idle_cycles(1);

    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    idle_cycles(1);

    abort_frame(8'hA5, 1'b0, CPB * 3 + 1);
    clear_with_valid();

    for (int n = 0; n < 12; n++) begin
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(0, 2));
    end

    for (int n = 0; n < 3; n++)
      abort_frame(8'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(1, FRAME_BITS * CPB - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_tx_framer.md
# serial_tx_framer

- Downstream consumer of the 8-bit parallel shift-register stage.
- Accepts one byte per valid/ready handshake and transmits it on a single line as an asynchronous-style frame: start bit, 8 data bits in a selectable order, an optional parity bit, then a stop bit.
- Each bit is held for a programmable number of clock cycles.
- Provides the serial link-out path for the register datapath.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles each frame bit is held; legal range ≥1.
- `DATA_W`, default 8: data bits per frame; fixed at 8 for this revision.
- `Clk`  in  1: the only clock; all state updates on the falling edge, matching the upstream shift register.
- `Clear`  in  1: synchronous, active-high reset.
- `Data`  in  8 [0:7]: byte to send; sampled only on accept.
- `Dir`  in  1: bit order, sampled on accept.
  - 0: Data[0] first, Data[7] last.
  - 1: Data[7] first, Data[0] last.
- `Valid`  in  1: a byte is offered.
- `Ready`  out  1: framer can accept; high only in IDLE.
- `Tx`  out  1: serial line; idles high.
- `Busy`  out  1: high while any frame bit is on the line.
- `Done`  out  1: one-cycle pulse when the stop bit completes.

## Operation
- **States:** IDLE, START, DATA, PARITY (present only when compiled in), STOP.
- **IDLE:**
  - Tx=1, Ready=1, Busy=0.
  - On `Valid && Ready`: latch Data and Dir, clear the bit timer and bit index, and go to START.
- **START:**
  - Tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:**
  - Tx = latched bit selected by index and Dir, held CLKS_PER_BIT cycles per bit.
  - Index counts 0..7; after index 7 go to PARITY, or to STOP if parity is compiled out.
- **PARITY:** Tx = XOR of the 8 latched bits (even parity), held CLKS_PER_BIT cycles, then go to STOP.
- **STOP:** Tx=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse Done for exactly that first IDLE cycle.
- **Bit timer:**
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - A state or bit advance occurs on the cycle the timer equals CLKS_PER_BIT-1.
  - Width is clog2(CLKS_PER_BIT), minimum 1.
- **Input isolation:** Data, Dir and Valid changes during a frame are ignored. Latched copies alone drive Tx.
- **Clear:**
  - Dominates everything, at any point including mid-frame.
  - Next edge: state=IDLE, Tx=1, Ready=1, Busy=0, Done=0, timer=0, index=0.
  - The aborted frame is not resumed.
- **Clear with Valid:** if Clear and Valid are both high on one edge, Clear wins and the byte is not accepted.

## Timing
- **Reset values:**
  - Tx=1, Ready=1, Busy=0, Done=0, state IDLE.
- **Output registration:** all outputs are registered; none are combinational from inputs.
- **Accept:**
  - Tx falls to 0 on the same edge that accepts the byte.
  - Ready and Busy update on that edge too.
- **Frame length:**
  - 10×CLKS_PER_BIT cycles without parity.
  - 11×CLKS_PER_BIT cycles with parity.
- **Back-to-back:**
  - Ready rises on the edge that ends STOP, at the same time as Done.
  - The earliest next accept is the following edge, so successive frames are separated by one idle-high cycle.
- **CLKS_PER_BIT=1:** every bit lasts exactly one cycle, and the timer stays at 0.

## Configuration
- **`SERIAL_TX_PARITY_EN`:**
  - Defined: the PARITY state exists, even parity is inserted between the last data bit and stop, and frames are 11 bits.
  - Undefined: the PARITY state and XOR logic are absent, DATA goes straight to STOP, and frames are 10 bits.
  - Port list is identical in both builds.

## Structure
- **Package `serial_pkg`:**
  - State encoding constants.
  - DATA_W.
  - FRAME_BITS, derived from the macro.
  - Idle line level.
- **Sub-module `bit_timer`:**
  - Parameterised by CLKS_PER_BIT.
  - Inputs: Clk, Clear, restart.
  - Output: a one-cycle `tick` on the final cycle of each bit period.
  - The framer FSM advances only on tick.

## Test plan
- Reset mid-DATA:
  - Clear high for 1 cycle at the 3rd data bit.
  - Next edge: Tx=1, Ready=1, Busy=0, Done=0.
  - No Done pulse follows.
- Data=8'h0F, Dir=0, CLKS_PER_BIT=4, parity out:
  - Tx sequence (4 cycles each) 0 | 0 0 0 0 1 1 1 1 | 1.
  - Done pulses 40 cycles after accept.
- Data=8'h0F, Dir=1:
  - data bits on line 1 1 1 1 0 0 0 0.
  - Input Data toggled to 8'hFF mid-frame has no effect.
- Parity build, Data=8'h07, Dir=0:
  - bits 0 0 0 0 0 1 1 1, parity bit 1, then stop.
  - Frame is 44 cycles.
- Back-to-back, Valid held high with 8'h55 then 8'hAA:
  - Done and Ready rise together.
  - Exactly one Tx=1 idle cycle occurs, then the second start bit.
- Clear and Valid high on the same edge: no accept, Tx stays 1, Ready stays 1.
